// File: rtl/l2_req_out_noc_tx.sv
// ---------------------------------------------------------------------------
// l2_req_out_noc_tx
//
// Purpose:
//   Downstream stage of the L2 core. Takes one outgoing coherence request per
//   handshake and serializes it onto the request NoC plane. The first flit is
//   a header. It is followed by one data flit for each word whose mask bit is
//   set, sent in ascending word order. Unmasked words are never sent.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   l2_req_out_valid/ready   request handshake from the L2 core
//   l2_req_out_coh_msg       coherence message
//   l2_req_out_hprot         hprot bit
//   l2_req_out_addr          line address
//   l2_req_out_word_mask     words targeted or carried
//   l2_req_out_line          line data, word i at [i*WORD_W +: WORD_W]
//   l2_req_out_has_data      message carries data words
//   l2_req_out_dest          destination tile
//   noc_flit_valid/ready     flit handshake toward the NoC
//   noc_flit                 {head, tail, payload}
//   busy                     a message is in flight
// ---------------------------------------------------------------------------
module l2_req_out_noc_tx #(
    parameter int LINE_ADDR_W    = 28,
    parameter int WORD_W         = 64,
    parameter int WORDS_PER_LINE = 4,
    parameter int MSG_W          = 5,
    parameter int DEST_W         = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             l2_req_out_valid,
    output logic                             l2_req_out_ready,
    input  logic [MSG_W-1:0]                 l2_req_out_coh_msg,
    input  logic                             l2_req_out_hprot,
    input  logic [LINE_ADDR_W-1:0]           l2_req_out_addr,
    input  logic [WORDS_PER_LINE-1:0]        l2_req_out_word_mask,
    input  logic [WORD_W*WORDS_PER_LINE-1:0] l2_req_out_line,
    input  logic                             l2_req_out_has_data,
    input  logic [DEST_W-1:0]                l2_req_out_dest,
    output logic                             noc_flit_valid,
    input  logic                             noc_flit_ready,
    output logic [WORD_W+1:0]                noc_flit,
    output logic                             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HEAD = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [WORDS_PER_LINE-1:0] MASK_ONE = WORDS_PER_LINE'(1);

    state_t                             state_q, state_d;
    logic [DEST_W-1:0]                  dest_q, dest_d;
    logic [MSG_W-1:0]                   msg_q, msg_d;
    logic                               hprot_q, hprot_d;
    logic [LINE_ADDR_W-1:0]             addr_q, addr_d;
    logic [WORDS_PER_LINE-1:0]          mask_q, mask_d;
    logic [WORD_W*WORDS_PER_LINE-1:0]   line_q, line_d;
    logic [WORDS_PER_LINE-1:0]          rem_q, rem_d;

    logic                               is_tail;
    logic                               flit_hs;
    logic                               tail_hs;
    logic                               accept;
    logic [WORDS_PER_LINE-1:0]          low_bit;
    logic [WORD_W-1:0]                  header;
    logic [WORD_W-1:0]                  data_word;
    logic                               head_bit;
    logic [WORD_W-1:0]                  payload;

    // State and capture registers. Reset abandons any message in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            dest_q  <= '0;
            msg_q   <= '0;
            hprot_q <= 1'b0;
            addr_q  <= '0;
            mask_q  <= '0;
            line_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            dest_q  <= dest_d;
            msg_q   <= msg_d;
            hprot_q <= hprot_d;
            addr_q  <= addr_d;
            mask_q  <= mask_d;
            line_q  <= line_d;
            rem_q   <= rem_d;
        end
    end

    // Tail detection and the handshakes that drive the state machine. The
    // core sees ready in the same cycle the tail flit leaves, so a new request
    // goes straight to HEAD without an idle bubble.
    always_comb begin
        low_bit = rem_q & (~rem_q + MASK_ONE);
        is_tail = 1'b0;
        if (state_q == HEAD) begin
            is_tail = (rem_q == '0);
        end else if (state_q == DATA) begin
            is_tail = ((rem_q & (rem_q - MASK_ONE)) == '0);
        end
        flit_hs          = noc_flit_valid & noc_flit_ready;
        tail_hs          = flit_hs & is_tail;
        l2_req_out_ready = (state_q == IDLE) | tail_hs;
        accept           = l2_req_out_valid & l2_req_out_ready;
    end

    // Next-state logic. A fresh capture takes priority over clearing the
    // bit of a DATA word that completes the previous message.
    always_comb begin
        state_d = state_q;
        dest_d  = dest_q;
        msg_d   = msg_q;
        hprot_d = hprot_q;
        addr_d  = addr_q;
        mask_d  = mask_q;
        line_d  = line_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = HEAD;
                end
            end
            HEAD, DATA: begin
                if (flit_hs) begin
                    if (is_tail) begin
                        state_d = accept ? HEAD : IDLE;
                    end else begin
                        state_d = DATA;
                    end
                    if (state_q == DATA) begin
                        rem_d = rem_q & ~low_bit;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            dest_d  = l2_req_out_dest;
            msg_d   = l2_req_out_coh_msg;
            hprot_d = l2_req_out_hprot;
            addr_d  = l2_req_out_addr;
            mask_d  = l2_req_out_word_mask;
            line_d  = l2_req_out_line;
            rem_d   = l2_req_out_has_data ? l2_req_out_word_mask : '0;
        end
    end

    // Flit assembly. Everything comes from registers, so the flit holds
    // steady while the NoC stalls. The downward scan leaves the lowest
    // pending word selected.
    always_comb begin
        header = '0;
        header[WORD_W-1 -: DEST_W]                          = dest_q;
        header[WORD_W-DEST_W-1 -: MSG_W]                    = msg_q;
        header[WORD_W-DEST_W-MSG_W-1]                       = hprot_q;
        header[WORD_W-DEST_W-MSG_W-2 -: WORDS_PER_LINE]     = mask_q;
        header[LINE_ADDR_W-1:0]                             = addr_q;

        data_word = '0;
        for (int i = WORDS_PER_LINE - 1; i >= 0; i--) begin
            if (rem_q[i]) begin
                data_word = line_q[i*WORD_W +: WORD_W];
            end
        end

        noc_flit_valid = (state_q != IDLE);
        busy           = (state_q != IDLE);
        head_bit       = (state_q == HEAD);
        payload        = '0;
        if (state_q == HEAD) begin
            payload = header;
        end else if (state_q == DATA) begin
            payload = data_word;
        end
        noc_flit = noc_flit_valid ? {head_bit, is_tail, payload} : '0;
    end

endmodule

// File: tb/tb_l2_req_out_noc_tx.sv
// ---------------------------------------------------------------------------
// tb_l2_req_out_noc_tx
//
// Testbench for l2_req_out_noc_tx. A queue of expected flits is built from
// each accepted request: the header, then the masked words in ascending
// order. Every cycle the bench compares the DUT's valid, ready, busy and
// current flit against the head of that queue. The test runs a table of
// vectors, then hand-written corner cases, then random traffic.
// ---------------------------------------------------------------------------
module tb_l2_req_out_noc_tx;

    localparam int LINE_ADDR_W    = 28;
    localparam int WORD_W         = 64;
    localparam int WORDS_PER_LINE = 4;
    localparam int MSG_W          = 5;
    localparam int DEST_W         = 4;

    logic         clk;
    logic         rst;
    logic         l2_req_out_valid;
    logic         l2_req_out_ready;
    logic [4:0]   l2_req_out_coh_msg;
    logic         l2_req_out_hprot;
    logic [27:0]  l2_req_out_addr;
    logic [3:0]   l2_req_out_word_mask;
    logic [255:0] l2_req_out_line;
    logic         l2_req_out_has_data;
    logic [3:0]   l2_req_out_dest;
    logic         noc_flit_valid;
    logic         noc_flit_ready;
    logic [65:0]  noc_flit;
    logic         busy;

    l2_req_out_noc_tx #(
        .LINE_ADDR_W    (LINE_ADDR_W),
        .WORD_W         (WORD_W),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .MSG_W          (MSG_W),
        .DEST_W         (DEST_W)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .l2_req_out_valid     (l2_req_out_valid),
        .l2_req_out_ready     (l2_req_out_ready),
        .l2_req_out_coh_msg   (l2_req_out_coh_msg),
        .l2_req_out_hprot     (l2_req_out_hprot),
        .l2_req_out_addr      (l2_req_out_addr),
        .l2_req_out_word_mask (l2_req_out_word_mask),
        .l2_req_out_line      (l2_req_out_line),
        .l2_req_out_has_data  (l2_req_out_has_data),
        .l2_req_out_dest      (l2_req_out_dest),
        .noc_flit_valid       (noc_flit_valid),
        .noc_flit_ready       (noc_flit_ready),
        .noc_flit             (noc_flit),
        .busy                 (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  msg;
        logic        hprot;
        logic [27:0] addr;
        logic [3:0]  mask;
        logic        hasData;
        logic [3:0]  dest;
        int          expFlits;
    } vec_t;

    vec_t         vecs[7];
    logic [65:0]  expq[$];
    logic [255:0] testLine;
    logic [65:0]  lastHsFlit;
    logic [65:0]  prevFlit;
    logic         prevStall;
    logic         lastAccepted;
    int           total;
    int           bad;
    int           hsCount;
    int           busyCnt;

    // Compare one observed value with its expected value and count the result.
    task automatic checkOutput(input string name, input logic [65:0] act, input logic [65:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Build the expected flit sequence of a request from its fields.
    function automatic void pushReq();
        logic [63:0] hdr;
        logic [3:0]  m;
        int          n;
        int          sent;
        m = l2_req_out_has_data ? l2_req_out_word_mask : 4'b0000;
        n = 0;
        for (int i = 0; i < 4; i++) n += int'(m[i]);
        hdr = (64'(l2_req_out_dest) << 60) | (64'(l2_req_out_coh_msg) << 55)
            | (64'(l2_req_out_hprot) << 54) | (64'(l2_req_out_word_mask) << 50)
            | 64'(l2_req_out_addr);
        expq.push_back({1'b1, (n == 0), hdr});
        sent = 0;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) begin
                sent++;
                expq.push_back({1'b0, (sent == n), l2_req_out_line[i*64 +: 64]});
            end
        end
    endfunction

    // One clock cycle. Outputs are checked on the falling edge. The model is
    // updated on the rising edge, and new inputs may be driven 1 time unit later.
    task automatic step();
        logic expValid;
        logic expReady;
        logic flitHs;
        logic acc;
        @(negedge clk);
        expValid = (expq.size() != 0);
        expReady = (expq.size() == 0) || (noc_flit_ready && expq.size() == 1);
        checkOutput("flit_valid", 66'(noc_flit_valid), 66'(expValid));
        checkOutput("req_ready", 66'(l2_req_out_ready), 66'(expReady));
        checkOutput("busy", 66'(busy), 66'(expValid));
        if (expValid) checkOutput("flit", noc_flit, expq[0]);
        if (prevStall) checkOutput("flit_hold", noc_flit, prevFlit);
        prevStall = noc_flit_valid && !noc_flit_ready;
        prevFlit  = noc_flit;
        if (busy) busyCnt++;
        flitHs = expValid && noc_flit_ready;
        acc    = l2_req_out_valid && expReady;
        if (flitHs) lastHsFlit = noc_flit;
        @(posedge clk);
        if (flitHs) begin
            void'(expq.pop_front());
            hsCount++;
        end
        if (acc) pushReq();
        lastAccepted = acc;
        #1;
    endtask

    // Present one request and hold it until it is accepted.
    task automatic applyStimulus(input vec_t v);
        int waitCycles;
        l2_req_out_coh_msg   = v.msg;
        l2_req_out_hprot     = v.hprot;
        l2_req_out_addr      = v.addr;
        l2_req_out_word_mask = v.mask;
        l2_req_out_has_data  = v.hasData;
        l2_req_out_dest      = v.dest;
        l2_req_out_line      = testLine;
        l2_req_out_valid     = 1'b1;
        waitCycles = 0;
        lastAccepted = 1'b0;
        while (!lastAccepted && waitCycles < 30) begin
            step();
            waitCycles++;
        end
        if (!lastAccepted) begin
            total++;
            bad++;
            $display("[TB] FAIL accept_timeout actual=0 required=1");
        end
        l2_req_out_valid = 1'b0;
    endtask

    // Run cycles until every expected flit has left, bounded by a cycle budget.
    task automatic drain(input logic toggle);
        int c;
        c = 0;
        while (expq.size() != 0 && c < 80) begin
            if (toggle) noc_flit_ready = ((c % 4) == 0) || ((c % 4) == 3);
            step();
            c++;
        end
        noc_flit_ready = 1'b1;
        if (expq.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain_timeout actual=%0d required=0", expq.size());
            expq.delete();
        end
    endtask

    initial begin
        int base;
        int c;
        vec_t v;
        total = 0; bad = 0; hsCount = 0; busyCnt = 0;
        prevStall = 1'b0; prevFlit = '0; lastHsFlit = '0; lastAccepted = 1'b0;
        for (int i = 0; i < 4; i++) testLine[i*64 +: 64] = 64'hC0DE_0000_0000_0000 | (64'(i + 1) * 64'h0101_0101);

        vecs[0] = '{5'd1,  1'b0, 28'h0ABCDE0, 4'b1111, 1'b0, 4'd3,  1};
        vecs[1] = '{5'd4,  1'b1, 28'h1234567, 4'b1010, 1'b1, 4'd7,  3};
        vecs[2] = '{5'd9,  1'b0, 28'hFFFFFFF, 4'b1111, 1'b1, 4'd15, 5};
        vecs[3] = '{5'd2,  1'b1, 28'h0000001, 4'b0000, 1'b1, 4'd0,  1};
        vecs[4] = '{5'd31, 1'b0, 28'h8000000, 4'b0101, 1'b0, 4'd9,  1};
        vecs[5] = '{5'd16, 1'b1, 28'h5A5A5A5, 4'b1000, 1'b1, 4'd1,  2};
        vecs[6] = '{5'd7,  1'b0, 28'h0F0F0F0, 4'b0110, 1'b1, 4'd12, 3};

        rst = 1'b0;
        l2_req_out_valid = 1'b0;
        noc_flit_ready = 1'b0;
        l2_req_out_coh_msg = '0; l2_req_out_hprot = 1'b0; l2_req_out_addr = '0;
        l2_req_out_word_mask = '0; l2_req_out_line = '0; l2_req_out_has_data = 1'b0;
        l2_req_out_dest = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_valid", 66'(noc_flit_valid), 66'd0);
        checkOutput("reset_flit", noc_flit, 66'd0);
        checkOutput("reset_busy", 66'(busy), 66'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        noc_flit_ready = 1'b1;
        step();

        // Table-driven requests with an always-ready NoC.
        for (int i = 0; i < 7; i++) begin
            base = hsCount;
            applyStimulus(vecs[i]);
            drain(1'b0);
            checkOutput($sformatf("flit_count_%0d", i), 66'(hsCount - base), 66'(vecs[i].expFlits));
            if (i == 0) checkOutput("req_s_header", lastHsFlit, {2'b11, 64'h30BC_0000_00AB_CDE0});
        end

        // Full line under a toggling ready pattern.
        base = hsCount;
        applyStimulus(vecs[2]);
        drain(1'b1);
        checkOutput("backpressure_count", 66'(hsCount - base), 66'd5);

        // Back-to-back: one data word, then a header-only request.
        v = '{5'd3, 1'b0, 28'h0000ABC, 4'b0001, 1'b1, 4'd2, 2};
        base = hsCount;
        applyStimulus(v);
        applyStimulus(vecs[0]);
        checkOutput("b2b_cycles", 66'(hsCount - base), 66'd2);
        drain(1'b0);
        checkOutput("b2b_count", 66'(hsCount - base), 66'd3);

        // Degenerate case: has_data with an empty mask.
        busyCnt = 0;
        applyStimulus(vecs[3]);
        drain(1'b0);
        checkOutput("degenerate_busy", 66'(busyCnt), 66'd1);

        // Reset in the middle of a full-line message, after two data flits.
        base = hsCount;
        applyStimulus(vecs[2]);
        c = 0;
        while (hsCount - base < 3 && c < 20) begin
            step();
            c++;
        end
        checkOutput("pre_reset_flits", 66'(hsCount - base), 66'd3);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("midreset_valid", 66'(noc_flit_valid), 66'd0);
        checkOutput("midreset_busy", 66'(busy), 66'd0);
        expq.delete();
        prevStall = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        step();
        applyStimulus(vecs[1]);
        step();
        checkOutput("post_reset_head", 66'(lastHsFlit[65]), 66'd1);
        drain(1'b0);

        // Random traffic, with request fields changing every cycle.
        for (int k = 0; k < 400; k++) begin
            l2_req_out_valid     = 1'($urandom_range(0, 1));
            l2_req_out_coh_msg   = 5'($urandom);
            l2_req_out_hprot     = 1'($urandom);
            l2_req_out_addr      = 28'($urandom);
            l2_req_out_word_mask = 4'($urandom);
            l2_req_out_has_data  = 1'($urandom);
            l2_req_out_dest      = 4'($urandom);
            for (int w = 0; w < 8; w++) l2_req_out_line[w*32 +: 32] = $urandom;
            noc_flit_ready       = ($urandom_range(0, 3) != 0);
            step();
        end
        l2_req_out_valid = 1'b0;
        drain(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
